// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : 32-bit signed multiply/divide unit (radix-2 Booth multiply,
//            restoring divide) sharing a single adder/subtractor.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic        op_q;
  logic [32:0] acc;        // Booth accumulator or partial remainder
  logic [31:0] shreg;      // multiplier bits or quotient bits
  logic [31:0] mcand;      // multiplicand or divisor magnitude
  logic        qm1;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] add_x;
  logic [32:0] add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic [32:0] acc_nxt;
  logic [31:0] shreg_nxt;
  logic        qm1_nxt;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_by_zero;

  assign abs_a       = a[31] ? (~a + 32'd1) : a;
  assign abs_b       = b[31] ? (~b + 32'd1) : b;
  assign div_by_zero = op && (b == 32'd0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Single shared 33-bit adder: Booth add/sub for MULT, trial subtract for DIV.
  always_comb begin
    add_x     = acc;
    add_y     = 33'd0;
    add_cin   = 1'b0;
    acc_nxt   = acc;
    shreg_nxt = shreg;
    qm1_nxt   = qm1;
    if (op_q) begin
      add_x   = {acc[31:0], shreg[31]};
      add_y   = ~{1'b0, mcand};
      add_cin = 1'b1;
    end else if (shreg[0] && !qm1) begin
      add_y   = ~{mcand[31], mcand};
      add_cin = 1'b1;
    end else if (!shreg[0] && qm1) begin
      add_y   = {mcand[31], mcand};
    end
    sum = add_x + add_y + {32'd0, add_cin};
    if (op_q) begin
      qm1_nxt = 1'b0;
      if (!sum[32]) begin
        acc_nxt   = sum;
        shreg_nxt = {shreg[30:0], 1'b1};
      end else begin
        acc_nxt   = add_x;
        shreg_nxt = {shreg[30:0], 1'b0};
      end
    end else begin
      acc_nxt   = {sum[32], sum[32:1]};
      shreg_nxt = {sum[0], shreg[31:1]};
      qm1_nxt   = shreg[0];
    end
  end

  // Division runs on magnitudes; signs are restored when results are written.
  assign quo_fin = neg_q ? (~shreg_nxt + 32'd1) : shreg_nxt;
  assign rem_fin = neg_r ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = div_by_zero ? DONE : RUN;
      RUN:  if (count == LAST_ITER) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= 5'd0;
      op_q     <= 1'b0;
      acc      <= 33'd0;
      shreg    <= 32'd0;
      mcand    <= 32'd0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count    <= 5'd0;
            div_zero <= div_by_zero;
            if (!div_by_zero) begin
              op_q  <= op;
              acc   <= 33'd0;
              qm1   <= 1'b0;
              shreg <= op ? abs_a : a;
              mcand <= op ? abs_b : b;
              neg_q <= a[31] ^ b[31];
              neg_r <= a[31];
            end
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          shreg <= shreg_nxt;
          qm1   <= qm1_nxt;
          count <= count + 5'd1;
          if (count == LAST_ITER) begin
            if (op_q) begin
              hi <= rem_fin;
              lo <= quo_fin;
            end else begin
              hi <= acc_nxt[31:0];
              lo <= shreg_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : self-checking bench for mult_div_unit against a 64-bit arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Architectural model: what HI/LO/div_zero/latency must be after an op.
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int elat);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o && y == 32'd0) begin
      eh = m_hi; el = m_lo; edz = 1'b1; elat = 0;
    end else begin
      if (!o) begin
        p = sx * sy;
        eh = p[63:32]; el = p[31:0];
      end else begin
        q = sx / sy;
        r = sx % sy;
        eh = r[31:0]; el = q[31:0];
      end
      edz = 1'b0; elat = 32;
      m_hi = eh; m_lo = el;
    end
  endfunction

  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r_hi, output logic [31:0] r_lo,
                       output logic r_dz, output int lat, output bit busy_ok);
    int guard;
    busy_ok = 1'b1;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ($urandom_range(1) != 0); a = $urandom; b = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    else if (!busy) busy_ok = 1'b0;
    r_hi = hi; r_lo = lo; r_dz = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    total_cnt++;
    if ({busy, done, hi, lo, div_zero} !== 67'd0)
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h dz=%b want all 0",
               busy, done, hi, lo, div_zero);
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] dx [5] = '{32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] dy [5] = '{32'hFFFFFFFD, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] x, y, e_hi, e_lo, r_hi, r_lo;
    logic e_dz, r_dz;
    int elat, lat;
    bit bok;
    for (int i = 0; i < 21; i++) begin
      x = (i < 5) ? dx[i] : $urandom;
      y = (i < 5) ? dy[i] : $urandom;
      model(1'b0, x, y, e_hi, e_lo, e_dz, elat);
      do_op(1'b0, x, y, r_hi, r_lo, r_dz, lat, bok);
      total_cnt++;
      if ({r_hi, r_lo, r_dz} !== {e_hi, e_lo, e_dz})
        $display("FAIL mult a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                 x, y, r_hi, r_lo, r_dz, e_hi, e_lo, e_dz);
      else pass_cnt++;
      total_cnt++;
      if (lat !== elat || !bok)
        $display("FAIL mult_latency a=%h b=%h got %0d busy_ok=%b want %0d busy_ok=1",
                 x, y, lat, bok, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [31:0] dx [6] = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFFF9, 32'd1, 32'h3412};
    logic [31:0] dy [6] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'h100};
    logic [31:0] x, y, e_hi, e_lo, r_hi, r_lo;
    logic e_dz, r_dz;
    int elat, lat;
    bit bok;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) begin
        x = $urandom;
        y = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
        if (i % 4 == 0) y = ~y + 32'd1;
        if (y == 32'd0) y = 32'd1;
      end else begin
        x = dx[i-16];
        y = dy[i-16];
      end
      model(1'b1, x, y, e_hi, e_lo, e_dz, elat);
      do_op(1'b1, x, y, r_hi, r_lo, r_dz, lat, bok);
      total_cnt++;
      if ({r_hi, r_lo, r_dz} !== {e_hi, e_lo, e_dz})
        $display("FAIL div a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                 x, y, r_hi, r_lo, r_dz, e_hi, e_lo, e_dz);
      else pass_cnt++;
      total_cnt++;
      if (lat !== elat || !bok)
        $display("FAIL div_latency a=%h b=%h got %0d busy_ok=%b want %0d busy_ok=1",
                 x, y, lat, bok, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] e_hi, e_lo, r_hi, r_lo;
    logic e_dz, r_dz;
    int elat, lat;
    bit bok;
    model(1'b1, 32'd5, 32'd0, e_hi, e_lo, e_dz, elat);
    do_op(1'b1, 32'd5, 32'd0, r_hi, r_lo, r_dz, lat, bok);
    total_cnt++;
    if ({r_hi, r_lo, r_dz, lat} !== {32'h12, 32'h34, 1'b1, 32'd0} || !bok)
      $display("FAIL div_zero got hi=%h lo=%h dz=%b lat=%0d busy_ok=%b want hi=12 lo=34 dz=1 lat=0 busy_ok=1",
               r_hi, r_lo, r_dz, lat, bok);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, div_zero} !== 3'b001)
      $display("FAIL div_zero_after got busy=%b done=%b dz=%b want busy=0 done=0 dz=1",
               busy, done, div_zero);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] x, y, e_hi, e_lo, prior_hi;
    logic e_dz;
    int elat, n;
    x = $urandom; y = $urandom;
    prior_hi = m_hi;
    model(1'b0, x, y, e_hi, e_lo, e_dz, elat);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
    total_cnt++;
    if (hi !== prior_hi)
      $display("FAIL hi_hold_mid_run got %h want %h", hi, prior_hi);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    n = 11;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if ({hi, lo, div_zero} !== {e_hi, e_lo, 1'b0} || n != 32)
      $display("FAIL start_ignored got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=0 lat=32",
               hi, lo, div_zero, n, e_hi, e_lo);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL start_not_queued got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] e_hi, e_lo, r_hi, r_lo;
    logic e_dz, r_dz;
    int elat, lat;
    bit bok;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hFFFFFFCE; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, hi, lo, div_zero} !== 67'd0)
      $display("FAIL reset_mid_run got busy=%b done=%b hi=%h lo=%h dz=%b want all 0",
               busy, done, hi, lo, div_zero);
    else pass_cnt++;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); reset = 1'b1;
    model(1'b1, 32'd100, 32'd7, e_hi, e_lo, e_dz, elat);
    do_op(1'b1, 32'd100, 32'd7, r_hi, r_lo, r_dz, lat, bok);
    total_cnt++;
    if ({r_hi, r_lo, r_dz, lat} !== {32'd2, 32'd14, 1'b0, 32'd32} || !bok)
      $display("FAIL div_after_reset got hi=%0d lo=%0d dz=%b lat=%0d want hi=2 lo=14 dz=0 lat=32",
               r_hi, r_lo, r_dz, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, e_hi, e_lo, r_hi, r_lo;
    logic o, e_dz, r_dz;
    int elat, lat;
    bit bok;
    for (int i = 0; i < 10; i++) begin
      o = i[0];
      x = $urandom;
      y = (i == 5) ? 32'd0 : $urandom;
      if (o && i != 5 && y == 32'd0) y = 32'd3;
      model(o, x, y, e_hi, e_lo, e_dz, elat);
      do_op(o, x, y, r_hi, r_lo, r_dz, lat, bok);
      total_cnt++;
      if ({r_hi, r_lo, r_dz} !== {e_hi, e_lo, e_dz} || lat !== elat || !bok)
        $display("FAIL back_to_back op=%b a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=%b lat=%0d",
                 o, x, y, r_hi, r_lo, r_dz, lat, e_hi, e_lo, e_dz, elat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
